// File: rtl/debug_unit.sv
// debug_unit: run-control and debug-dump controller sitting between the
// pipelined MIPS core and the UART byte FIFOs.
//   'c' -> run the core until PC_plus_1 reaches END_PC, then dump
//   's' -> advance the core one cycle, then dump
//   'd' -> dump only
// A dump streams the core debug bus LSB byte first, zero-padded to whole bytes.
// Optional feature macro: DEBUG_CYCLE_COUNT_EN appends a 32-bit count of
// enabled core cycles above the payload (4 extra bytes, LSB first).
module debug_unit #(
  parameter int                  DEBUG_WIDTH = 322,
  parameter int                  PC_WIDTH    = 10,
  parameter logic [PC_WIDTH-1:0] END_PC      = 10'd63,
  parameter logic [7:0]          CMD_RUN     = 8'h63,
  parameter logic [7:0]          CMD_STEP    = 8'h73,
  parameter logic [7:0]          CMD_DUMP    = 8'h64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DEBUG_WIDTH-1:0] debug_signal,
  input  logic [PC_WIDTH-1:0]    PC_plus_1,
  input  logic [7:0]             r_data,
  input  logic                   rx_empty,
  output logic                   rd,
  input  logic                   tx_full,
  output logic [7:0]             w_data,
  output logic                   wr,
  output logic                   enable_clk,
  output logic                   busy
);

  localparam int PAYLOAD_BYTES = (DEBUG_WIDTH + 7) / 8;
  localparam int PAYLOAD_W     = PAYLOAD_BYTES * 8;
`ifdef DEBUG_CYCLE_COUNT_EN
  localparam int NBYTES        = PAYLOAD_BYTES + 4;
`else
  localparam int NBYTES        = PAYLOAD_BYTES;
`endif
  localparam int SHIFT_W       = NBYTES * 8;
  localparam int CNT_W         = $clog2(NBYTES);

  typedef enum logic [2:0] {
    IDLE, READ, DECODE, RUN, STEP, LOAD, SEND
  } state_t;

  state_t             state, next_state;
  logic [7:0]         cmd;
  logic [SHIFT_W-1:0] shift;
  logic [SHIFT_W-1:0] snapshot;
  logic [CNT_W-1:0]   byte_cnt;
  logic               last_byte;
  logic               rd_d, wr_d, enable_d, busy_d;

  assign last_byte = (byte_cnt == CNT_W'(NBYTES - 1));

`ifdef DEBUG_CYCLE_COUNT_EN
  logic [31:0] cycle_count;

  // Count every cycle the core is allowed to advance; only reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           cycle_count <= '0;
    else if (enable_clk) cycle_count <= cycle_count + 32'd1;
  end

  assign snapshot = {cycle_count, PAYLOAD_W'(debug_signal)};
`else
  assign snapshot = SHIFT_W'(debug_signal);
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so no path through the case leaves next_state
    // unassigned, which would infer a latch.
    next_state = state;
    case (state)
      IDLE:   if (!rx_empty) next_state = READ;
      READ:   next_state = DECODE;
      DECODE: begin
        if      (cmd == CMD_RUN)  next_state = RUN;
        else if (cmd == CMD_STEP) next_state = STEP;
        else if (cmd == CMD_DUMP) next_state = LOAD;
        else                      next_state = IDLE;
      end
      RUN:    if (PC_plus_1 == END_PC) next_state = LOAD;
      STEP:   next_state = LOAD;
      LOAD:   next_state = SEND;
      SEND:   if (!tx_full && last_byte) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode; outputs are looked up from the state being entered so the
  // registered versions line up with that state.
  always_comb begin
    rd_d     = (next_state == READ);
    wr_d     = (state == SEND) && !tx_full;
    enable_d = (next_state == RUN) || (next_state == STEP);
    busy_d   = (next_state != IDLE);
  end

  // Output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd         <= 1'b0;
      wr         <= 1'b0;
      enable_clk <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rd         <= rd_d;
      wr         <= wr_d;
      enable_clk <= enable_d;
      busy       <= busy_d;
    end
  end

  // Command capture, snapshot shift register and byte counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd      <= '0;
      shift    <= '0;
      byte_cnt <= '0;
      w_data   <= '0;
    end else begin
      case (state)
        READ: cmd <= r_data;
        LOAD: begin
          shift    <= snapshot;
          byte_cnt <= '0;
        end
        SEND: begin
          if (!tx_full) begin
            w_data   <= shift[7:0];
            shift    <= shift >> 8;
            byte_cnt <= byte_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
